key_capture: RTL and testbench

KEY_CAPTURE -- requirements
Module: key_capture

---
 rtl/key_capture_pkg.sv | 20 ++
 rtl/key_debounce.sv | 78 +++++++
 rtl/key_capture.sv | 102 ++++++++++
 tb/tb_key_capture.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// Shared IO package: debounce FSM encoding and the memory-mapped IO addresses.
package key_capture_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam logic [31:0] DISPLAY_ADDR  = 32'hFFFF_FFF0;
  localparam logic [31:0] KEY_DATA_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY_STAT_ADDR = 32'hFFFF_FFFC;

  // Counter just wide enough to reach cycles-1, so it saturates rather than wraps.
  function automatic int cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer for button and switches, followed by the press/release debounce FSM.
module key_debounce
  import key_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned SW_W            = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            btn_i,
  input  logic [SW_W-1:0] sw_i,
  output logic            level_o,
  output logic            press_o,
  output logic [SW_W-1:0] sw_sync_o,
  output deb_state_e      state_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic            btn_s1_q, btn_s2_q;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  deb_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic            cnt_at_max;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_i;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_i;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign cnt_at_max = (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (btn_s2_q) begin
          state_q <= PRESS_WAIT;
          cnt_q   <= '0;
        end
        PRESS_WAIT: begin
          if (!btn_s2_q)       state_q <= IDLE;
          else if (cnt_at_max) state_q <= HELD;
          else                 cnt_q   <= cnt_q + 1'b1;
        end
        HELD: if (!btn_s2_q) begin
          state_q <= RELEASE_WAIT;
          cnt_q   <= '0;
        end
        RELEASE_WAIT: begin
          if (btn_s2_q)        state_q <= HELD;
          else if (cnt_at_max) state_q <= IDLE;
          else                 cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe is high in the cycle whose closing edge commits PRESS_WAIT -> HELD.
  assign press_o   = (state_q == PRESS_WAIT) && btn_s2_q && cnt_at_max;
  assign level_o   = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign sw_sync_o = sw_s2_q;
  assign state_o   = state_q;

endmodule

// File: rtl/key_capture.sv
// Memory-mapped key capture: debounced confirm button latches the switches for the CPU.
// Optional sticky overrun status bit enabled by defining KEY_CAPTURE_OVERRUN_EN.
module key_capture
  import key_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter logic [31:0] DATA_ADDR       = KEY_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR       = KEY_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        switchCtrl,
  input  logic [15:0] switchInput,
  input  logic        confirmation,
  input  logic [31:0] address,
  input  logic        readEn,
  output logic [15:0] dataIOInput,
  output logic        dataReady,
  output logic        pressPulse
);

  logic        press, btn_level, cap, rd_data, overrun;
  logic [15:0] sw_sync;
  deb_state_e  deb_state;
  logic [15:0] data_q, data_d;
  logic        ready_q, ready_d, pulse_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SW_W            (16)
  ) u_debounce (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_i     (confirmation),
    .sw_i      (switchInput),
    .level_o   (btn_level),
    .press_o   (press),
    .sw_sync_o (sw_sync),
    .state_o   (deb_state)
  );

  assign cap     = press & switchCtrl;
  assign rd_data = readEn && (address == DATA_ADDR);

  // A capture outranks a same-cycle clearing read.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    if (cap) begin
      data_d  = sw_sync;
      ready_d = 1'b1;
    end else if (rd_data) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 16'h0000;
      ready_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      pulse_q <= cap;
    end
  end

`ifdef KEY_CAPTURE_OVERRUN_EN
  logic rd_stat, ovr_q, ovr_d;
  assign rd_stat = readEn && (address == STAT_ADDR);

  always_comb begin
    ovr_d = ovr_q;
    if (cap && ready_q) ovr_d = 1'b1;
    else if (rd_stat)   ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  always_comb begin
    dataIOInput = 16'h0000;
    if (address == DATA_ADDR)      dataIOInput = data_q;
    else if (address == STAT_ADDR) dataIOInput = {14'b0, overrun, ready_q};
  end

  assign dataReady  = ready_q;
  assign pressPulse = pulse_q;

  // The press strobe only ever fires from PRESS_WAIT, before the level goes high.
  a_press_from_wait: assert property (@(posedge clk) disable iff (rst)
    press |-> (deb_state == PRESS_WAIT) && !btn_level);

endmodule

// File: tb/tb_key_capture.sv
// Randomized scoreboard bench for key_capture with a run-length debounce reference model.
module tb_key_capture;

  localparam int unsigned DEB       = 4;
  localparam int unsigned LATENCY   = 2 + DEB;
  localparam logic [31:0] DATA_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, switchCtrl, confirmation, readEn;
  logic [15:0] switchInput;
  logic [31:0] address;
  logic [15:0] dataIOInput;
  logic        dataReady, pressPulse;

  int checks   = 0;
  int failures = 0;

  key_capture #(
    .DEBOUNCE_CYCLES (DEB),
    .DATA_ADDR       (DATA_ADDR),
    .STAT_ADDR       (STAT_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switchCtrl   (switchCtrl),
    .switchInput  (switchInput),
    .confirmation (confirmation),
    .address      (address),
    .readEn       (readEn),
    .dataIOInput  (dataIOInput),
    .dataReady    (dataReady),
    .pressPulse   (pressPulse)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Debounced level flips after DEB+1 consecutive synced samples disagreeing with it;
  // a flip to 1 is an accepted press.
  int unsigned cyc = 0;
  logic        m_p1, m_p2, m_level;
  logic [15:0] m_s1, m_s2, m_data;
  logic        m_ready, m_ovr;
  int          m_run;
  logic [47:0] exp_q[$];

  always @(posedge clk) begin : model
    logic m_press, m_cap, m_rd_d, m_rd_s;
    cyc++;
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_s1 = 0; m_s2 = 0;
      m_level = 0; m_run = 0; m_data = 0; m_ready = 0; m_ovr = 0;
    end else begin
      m_press = 1'b0;
      if (m_p2 != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = m_p2;
          m_run   = 0;
          m_press = m_level;
        end
      end else begin
        m_run = 0;
      end
      m_cap  = m_press && switchCtrl;
      m_rd_d = readEn && (address == DATA_ADDR);
      m_rd_s = readEn && (address == STAT_ADDR);
`ifdef KEY_CAPTURE_OVERRUN_EN
      if (m_cap && m_ready) m_ovr = 1'b1;
      else if (m_rd_s)      m_ovr = 1'b0;
`endif
      if (m_cap) begin
        m_data  = m_s2;
        m_ready = 1'b1;
        exp_q.push_back({cyc[31:0], m_s2});
      end else if (m_rd_d) begin
        m_ready = 1'b0;
      end
      m_p2 = m_p1; m_p1 = confirmation;
      m_s2 = m_s1; m_s1 = switchInput;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] exp_rd;
    logic [47:0] e;
    if (address == DATA_ADDR)      exp_rd = m_data;
    else if (address == STAT_ADDR) exp_rd = {14'b0, m_ovr, m_ready};
    else                           exp_rd = 16'h0000;
    chk("rdata", {16'h0, dataIOInput}, {16'h0, exp_rd});
    chk("ready", {31'h0, dataReady}, {31'h0, m_ready});
    if (pressPulse) begin
      if (exp_q.size() == 0) begin
        chk("pulse_unexpected", {31'h0, pressPulse}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e[47:16]);
      end
    end else if (exp_q.size() != 0 && exp_q[0][47:16] <= cyc) begin
      e = exp_q.pop_front();
      chk("pulse_missing", {31'h0, pressPulse}, 32'h1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input string name, input int unsigned t_rise);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pressPulse) begin
        found = 1;
        chk(name, cyc - t_rise, LATENCY);
      end
    end
    if (!found) chk({name, "_timeout"}, {31'h0, pressPulse}, 32'h1);
  endtask

  task automatic peek(input string name, input logic [31:0] addr, input logic [15:0] exp);
    address = addr;
    readEn  = 1'b0;
    @(negedge clk);
    chk(name, {16'h0, dataIOInput}, {16'h0, exp});
  endtask

  task automatic read_strobe(input logic [31:0] addr);
    tick(1);
    address = addr;
    readEn  = 1'b1;
    tick(1);
    readEn  = 1'b0;
    address = DATA_ADDR;
  endtask

  task automatic press(input string name, input logic [15:0] sw);
    int unsigned t;
    tick(1);
    switchInput  = sw;
    confirmation = 1'b1;
    t = cyc + 1;
    wait_pulse(name, t);
  endtask

  task automatic release_btn();
    tick(1);
    confirmation = 1'b0;
    tick(DEB + 6);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int unsigned t;
    int n;
    rst = 1; switchCtrl = 1; switchInput = 0; confirmation = 0;
    address = DATA_ADDR; readEn = 0;
    tick(3);
    peek("reset_data", DATA_ADDR, 16'h0000);
    peek("reset_stat", STAT_ADDR, 16'h0000);
    chk("reset_pulse", {31'h0, pressPulse}, 32'h0);
    tick(1);
    rst = 0;
    tick(3);

    // clean press
    press("lat_clean", 16'hA5C3);
    peek("clean_stat", STAT_ADDR, 16'h0001);
    peek("clean_data", DATA_ADDR, 16'hA5C3);

    // clearing read while the button stays held
    read_strobe(DATA_ADDR);
    @(negedge clk);
    chk("ready_cleared", {31'h0, dataReady}, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pressPulse) n++;
    end
    chk("hold_no_repeat", n, 0);
    release_btn();

    // bounce then a steady press
    switchInput = 16'h5A5A;
    tick(3);
    confirmation = 1; tick(1); confirmation = 0; tick(1);
    confirmation = 1; tick(1); confirmation = 0; tick(1);
    confirmation = 1;
    t = cyc + 1;
    wait_pulse("lat_bounce", t);
    peek("bounce_data", DATA_ADDR, 16'h5A5A);
    release_btn();
    read_strobe(DATA_ADDR);

    // capture colliding with a clearing read
    switchInput = 16'h1234;
    tick(3);
    confirmation = 1'b1;
    tick(LATENCY);
    address = DATA_ADDR;
    readEn  = 1'b1;
    tick(1);
    readEn  = 1'b0;
    @(negedge clk);
    chk("collide_pulse", {31'h0, pressPulse}, 32'h1);
    chk("collide_ready", {31'h0, dataReady}, 32'h1);
    chk("collide_data", {16'h0, dataIOInput}, 32'h1234);
    release_btn();
    read_strobe(DATA_ADDR);

    // two captures with no read in between
    press("lat_ovr1", 16'h0F0F);
    release_btn();
    press("lat_ovr2", 16'hBEEF);
    release_btn();
`ifdef KEY_CAPTURE_OVERRUN_EN
    peek("ovr_stat", STAT_ADDR, 16'h0003);
`else
    peek("ovr_stat", STAT_ADDR, 16'h0001);
`endif
    peek("ovr_data", DATA_ADDR, 16'hBEEF);
    read_strobe(STAT_ADDR);
    peek("ovr_stat_after_read", STAT_ADDR, 16'h0001);

    // capture with switchCtrl low is ignored
    switchCtrl = 1'b0;
    tick(1);
    confirmation = 1'b1;
    tick(LATENCY + 4);
    peek("ctrl_off_data", DATA_ADDR, 16'hBEEF);
    release_btn();
    switchCtrl = 1'b1;

    // reset while in PRESS_WAIT, button held throughout
    switchInput  = 16'hC0DE;
    confirmation = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    peek("rst_mid_data", DATA_ADDR, 16'h0000);
    peek("rst_mid_stat", STAT_ADDR, 16'h0000);
    chk("rst_mid_pulse", {31'h0, pressPulse}, 32'h0);
    tick(1);
    rst = 1'b0;
    t = cyc + 1;
    wait_pulse("lat_after_rst", t);
    peek("rst_after_data", DATA_ADDR, 16'hC0DE);
    release_btn();

    // randomized traffic
    for (int r = 0; r < 80; r++) begin
      int len;
      len = $urandom_range(1, 9);
      confirmation = 1'($urandom_range(0, 1));
      switchInput  = 16'($urandom);
      switchCtrl   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 2))
          0:       address = DATA_ADDR;
          1:       address = STAT_ADDR;
          default: address = $urandom;
        endcase
        readEn = ($urandom_range(0, 3) == 0);
        tick(1);
      end
    end
    readEn = 1'b0;
    confirmation = 1'b0;
    address = DATA_ADDR;
    tick(DEB + 10);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
